// File: rtl/periph_reg_arbiter_pkg.sv
// Shared constants, the index-width helper and the default register-interface
// request/response structs for the peripheral register arbiter.
package periph_reg_arbiter_pkg;

    localparam int unsigned DefAW = 32;
    localparam int unsigned DefDW = 32;
    localparam int unsigned DefBW = 8;
    localparam int unsigned DefSW = DefDW / DefBW;

    // A single port still needs a one-bit index so every select is legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stand-ins for the register-interface typedef macro output; an
    // integrating design overrides req_t/rsp_t with its own macro types.
    typedef struct packed {
        logic [DefAW-1:0] addr;
        logic             write;
        logic [DefDW-1:0] wdata;
        logic [DefSW-1:0] wstrb;
        logic             valid;
    } reg_req_t;

    typedef struct packed {
        logic [DefDW-1:0] rdata;
        logic             error;
        logic             ready;
    } reg_rsp_t;

endpackage

// File: rtl/periph_reg_arbiter_rr.sv
// Round-robin selector with lock override; owns the rotating priority
// pointer and produces the one-hot grant for the shared target.
module rr_arb_lock
    import periph_reg_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned IdxW     = idx_width(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] i_req,
    input  logic                i_lock,
    input  logic [IdxW-1:0]     i_sel_q,
    input  logic                i_ready,
    output logic [IdxW-1:0]     o_sel,
    output logic [NumPorts-1:0] o_gnt
);

    logic [IdxW-1:0] r_ptr_q;
    logic [IdxW-1:0] w_rr_sel;
    logic [IdxW-1:0] w_ptr_d;
    logic            w_found;
    int unsigned     w_cand;

    // First requester at or after the pointer, wrapping modulo NumPorts.
    always_comb begin
        w_rr_sel = r_ptr_q;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            w_cand = (32'(r_ptr_q) + i) % NumPorts;
            if (!w_found && i_req[IdxW'(w_cand)]) begin
                w_rr_sel = IdxW'(w_cand);
                w_found  = 1'b1;
            end
        end
    end

    assign o_sel   = i_lock ? i_sel_q : w_rr_sel;
    assign w_ptr_d = IdxW'((32'(o_sel) + 32'd1) % NumPorts);

    // Grant only the selected port, and only when the target accepts.
    always_comb begin
        o_gnt = '0;
        if (i_req[o_sel] && i_ready) begin
            o_gnt[o_sel] = 1'b1;
        end
    end

    // Priority rotates past the winner on every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr_q <= '0;
        end else if (|o_gnt) begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule

// File: rtl/periph_reg_arbiter.sv
// Shares one register-interface target between NumPorts crossbar requesters
// with a locked round-robin choice and a one-cycle registered response.
module periph_reg_arbiter
    import periph_reg_arbiter_pkg::*;
#(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned BW       = 8,
    parameter int unsigned IW       = 1,
    parameter type         req_t    = reg_req_t,
    parameter type         rsp_t    = reg_rsp_t
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumPorts-1:0]           req_i,
    input  logic [NumPorts-1:0][AW-1:0]   add_i,
    input  logic [NumPorts-1:0]           wen_i,
    input  logic [NumPorts-1:0][DW-1:0]   wdata_i,
    input  logic [NumPorts-1:0][DW/BW-1:0] be_i,
    input  logic [NumPorts-1:0][IW-1:0]   id_i,
    output logic [NumPorts-1:0]           gnt_o,
    output logic [NumPorts-1:0][DW-1:0]   r_rdata_o,
    output logic [NumPorts-1:0]           r_opc_o,
    output logic [NumPorts-1:0][IW-1:0]   r_id_o,
    output logic [NumPorts-1:0]           r_valid_o,
    output req_t                          reg_req_o,
    input  rsp_t                          reg_rsp_i
);

    localparam int unsigned IdxW = idx_width(NumPorts);

    logic                r_lock_q;
    logic [IdxW-1:0]     r_sel_q;
    logic                r_vld_q;
    logic [IdxW-1:0]     r_idx_q;
    logic [DW-1:0]       r_rdata_q;
    logic                r_opc_q;
    logic [IW-1:0]       r_id_q;

    logic [IdxW-1:0]     w_sel;
    logic [NumPorts-1:0] w_gnt;
    logic                w_valid;
    logic                w_ready;
    logic                w_any_gnt;

    rr_arb_lock #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_req    (req_i),
        .i_lock   (r_lock_q),
        .i_sel_q  (r_sel_q),
        .i_ready  (w_ready),
        .o_sel    (w_sel),
        .o_gnt    (w_gnt)
    );

    assign w_ready   = reg_rsp_i.ready;
    assign w_valid   = req_i[w_sel] & rst_ni;
    assign gnt_o     = w_gnt & {NumPorts{rst_ni}};
    assign w_any_gnt = |gnt_o;

    // Target request mirrors whichever port is currently selected.
    always_comb begin
        reg_req_o       = '0;
        reg_req_o.addr  = add_i[w_sel];
        reg_req_o.write = ~wen_i[w_sel];
        reg_req_o.wdata = wdata_i[w_sel];
        reg_req_o.wstrb = be_i[w_sel];
        reg_req_o.valid = w_valid;
    end

    // Hold the selection while a driven request waits on the target;
    // a grant or a dropped request both release it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lock_q <= 1'b0;
            r_sel_q  <= '0;
        end else begin
            r_lock_q <= w_valid & ~w_ready;
            if (w_valid && !w_ready) begin
                r_sel_q <= w_sel;
            end
        end
    end

    // Capture the target response and requester ID in the grant cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_q   <= 1'b0;
            r_idx_q   <= '0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_vld_q <= w_any_gnt;
            if (w_any_gnt) begin
                r_idx_q   <= w_sel;
                r_rdata_q <= reg_rsp_i.rdata;
                r_opc_q   <= reg_rsp_i.error;
                r_id_q    <= id_i[w_sel];
            end
        end
    end

    // Route the shared response onto its port; all others read zero.
    always_comb begin
        r_valid_o = '0;
        r_rdata_o = '0;
        r_opc_o   = '0;
        r_id_o    = '0;
        for (int unsigned k = 0; k < NumPorts; k++) begin
            if (r_vld_q && (r_idx_q == IdxW'(k))) begin
                r_valid_o[k] = 1'b1;
                r_rdata_o[k] = r_rdata_q;
                r_opc_o[k]   = r_opc_q;
                r_id_o[k]    = r_id_q;
            end
        end
    end

endmodule

// File: tb/tb_periph_reg_arbiter.sv
// Directed bench for periph_reg_arbiter: expected responses are queued at
// grant time and compared when the registered response appears.
module tb_periph_reg_arbiter;
    import periph_reg_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int IW = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [NP-1:0]          req_i = '0;
    logic [NP-1:0][31:0]    add_i;
    logic [NP-1:0]          wen_i = '1;
    logic [NP-1:0][31:0]    wdata_i;
    logic [NP-1:0][3:0]     be_i;
    logic [NP-1:0][IW-1:0]  id_i;
    logic [NP-1:0]          gnt_o;
    logic [NP-1:0][31:0]    r_rdata_o;
    logic [NP-1:0]          r_opc_o;
    logic [NP-1:0][IW-1:0]  r_id_o;
    logic [NP-1:0]          r_valid_o;
    reg_req_t               reg_req_o;
    reg_rsp_t               reg_rsp_i = '0;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        logic [IW-1:0] id;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail = 0;

    periph_reg_arbiter #(
        .NumPorts (NP),
        .AW       (32),
        .DW       (32),
        .BW       (8),
        .IW       (IW)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .wdata_i   (wdata_i),
        .be_i      (be_i),
        .id_i      (id_i),
        .gnt_o     (gnt_o),
        .r_rdata_o (r_rdata_o),
        .r_opc_o   (r_opc_o),
        .r_id_o    (r_id_o),
        .r_valid_o (r_valid_o),
        .reg_req_o (reg_req_o),
        .reg_rsp_i (reg_rsp_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check combinational grant/request, queue the expected
    // response on a grant, clock, then check the registered response.
    task automatic tick(input string tag, input logic [NP-1:0] eg,
                        input logic ev, input logic [31:0] ea);
        exp_t e;
        logic [NP-1:0]         ev_vec;
        logic [NP-1:0][31:0]   ed_vec;
        logic [NP-1:0]         eo_vec;
        logic [NP-1:0][IW-1:0] ei_vec;
        #1;
        chk({tag, ".gnt"}, 128'(gnt_o), 128'(eg));
        chk({tag, ".reqv"}, 128'(reg_req_o.valid), 128'(ev));
        if (ev) chk({tag, ".addr"}, 128'(reg_req_o.addr), 128'(ea));
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) begin
                e.port  = p;
                e.rdata = reg_rsp_i.rdata;
                e.err   = reg_rsp_i.error;
                e.id    = id_i[p];
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
        ev_vec = '0; ed_vec = '0; eo_vec = '0; ei_vec = '0;
        if (q.size() > 0) begin
            e = q.pop_front();
            ev_vec[e.port] = 1'b1;
            ed_vec[e.port] = e.rdata;
            eo_vec[e.port] = e.err;
            ei_vec[e.port] = e.id;
        end
        chk({tag, ".rvalid"}, 128'(r_valid_o), 128'(ev_vec));
        chk({tag, ".rdata"}, 128'(r_rdata_o), 128'(ed_vec));
        chk({tag, ".ropc"}, 128'(r_opc_o), 128'(eo_vec));
        chk({tag, ".rid"}, 128'(r_id_o), 128'(ei_vec));
    endtask

    initial begin
        int ord[3] = '{0, 1, 3};
        for (int i = 0; i < NP; i++) begin
            add_i[i]   = 32'h100 + 32'(i * 4);
            wdata_i[i] = 32'hA000_0000 + 32'(i);
            be_i[i]    = 4'hF;
            id_i[i]    = IW'(8 + i);
        end

        // Reset: grants and request valid gated even with requests present.
        req_i = 4'b1111;
        reg_rsp_i.ready = 1'b1;
        #3;
        chk("rst.gnt", 128'(gnt_o), 128'(0));
        chk("rst.reqv", 128'(reg_req_o.valid), 128'(0));
        chk("rst.rvalid", 128'(r_valid_o), 128'(0));
        chk("rst.rdata", 128'(r_rdata_o), 128'(0));
        req_i = '0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Round robin across ports 0,1,3.
        req_i = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                reg_rsp_i.rdata = $urandom();
                tick("rr", NP'(1) << ord[j], 1'b1, add_i[ord[j]]);
            end
        end
        req_i = '0;

        // Single read on port 2.
        req_i = 4'b0100;
        add_i[2] = 32'h40;
        id_i[2] = 4'h5;
        reg_rsp_i.rdata = 32'hDEADBEEF;
        #1;
        chk("rd.write", 128'(reg_req_o.write), 128'(0));
        tick("rd", 4'b0100, 1'b1, 32'h40);
        req_i = '0;
        tick("idle", 4'b0000, 1'b0, 32'h0);

        // Lock on port 1 while port 0 joins.
        req_i = 4'b0010;
        reg_rsp_i.ready = 1'b0;
        reg_rsp_i.rdata = 32'h1111_2222;
        tick("lk1", 4'b0000, 1'b1, add_i[1]);
        req_i = 4'b0011;
        tick("lk2", 4'b0000, 1'b1, add_i[1]);
        tick("lk3", 4'b0000, 1'b1, add_i[1]);
        reg_rsp_i.ready = 1'b1;
        tick("lk_g1", 4'b0010, 1'b1, add_i[1]);
        req_i = 4'b0001;
        reg_rsp_i.rdata = 32'h3333_4444;
        tick("lk_g0", 4'b0001, 1'b1, add_i[0]);
        req_i = '0;

        // Write with target error on port 3.
        req_i = 4'b1000;
        wen_i[3] = 1'b0;
        be_i[3] = 4'b0011;
        id_i[3] = 4'hA;
        reg_rsp_i.error = 1'b1;
        reg_rsp_i.rdata = 32'h0BAD_0BAD;
        #1;
        chk("wr.write", 128'(reg_req_o.write), 128'(1));
        chk("wr.wstrb", 128'(reg_req_o.wstrb), 128'(4'b0011));
        chk("wr.wdata", 128'(reg_req_o.wdata), 128'(32'hA000_0003));
        tick("wr", 4'b1000, 1'b1, add_i[3]);
        reg_rsp_i.error = 1'b0;
        wen_i[3] = 1'b1;
        req_i = '0;

        // Locked port 2 drops its request; pending port 0 wins afterwards.
        req_i = 4'b0100;
        reg_rsp_i.ready = 1'b0;
        tick("dr1", 4'b0000, 1'b1, add_i[2]);
        req_i = 4'b0001;
        tick("dr2", 4'b0000, 1'b0, 32'h0);
        reg_rsp_i.ready = 1'b1;
        reg_rsp_i.rdata = 32'h5555_6666;
        tick("dr3", 4'b0001, 1'b1, add_i[0]);
        req_i = '0;

        // Reset with a response showing and port 3 waiting on the target.
        req_i = 4'b0010;
        reg_rsp_i.rdata = 32'h7777_8888;
        tick("pre", 4'b0010, 1'b1, add_i[1]);
        req_i = 4'b1000;
        reg_rsp_i.ready = 1'b0;
        #1;
        chk("pre.reqv", 128'(reg_req_o.valid), 128'(1));
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid.rvalid", 128'(r_valid_o), 128'(0));
        chk("mid.rdata", 128'(r_rdata_o), 128'(0));
        chk("mid.rid", 128'(r_id_o), 128'(0));
        chk("mid.gnt", 128'(gnt_o), 128'(0));
        chk("mid.reqv", 128'(reg_req_o.valid), 128'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        req_i = 4'b1010;
        reg_rsp_i.ready = 1'b1;
        reg_rsp_i.rdata = 32'h9999_AAAA;
        tick("post1", 4'b0010, 1'b1, add_i[1]);
        reg_rsp_i.rdata = 32'hBBBB_CCCC;
        tick("post3", 4'b1000, 1'b1, add_i[3]);
        req_i = '0;
        tick("end", 4'b0000, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
